// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
package sar_pkg;

    // Widest probe the offset helpers can handle.
    localparam int unsigned SarMaxW = 64;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROBE = 2'd1,
        S_DONE  = 2'd2
    } sar_state_e;

    // Two's complement -> offset-binary for a w-bit value (flip the sign bit).
    function automatic logic [SarMaxW-1:0] to_offset(input logic [SarMaxW-1:0] v,
                                                     input int unsigned w);
        return v ^ (SarMaxW'(1) << (w - 1));
    endfunction

    // Offset-binary -> two's complement for a w-bit value (flip the sign bit).
    function automatic logic [SarMaxW-1:0] from_offset(input logic [SarMaxW-1:0] v,
                                                       input int unsigned w);
        return v ^ (SarMaxW'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/sar_search.sv
// Successive-approximation search controller: recovers a signed N-bit target that is
// only observable through a "probe > target" comparator.
// Optional build macro SAR_EARLY_EXIT_EN adds a probe_eq input that ends the search
// as soon as the responder reports an exact match.
// N must be in 2..64.
module sar_search
    import sar_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic signed [N-1:0] probe,
    output logic                probe_valid,
    input  logic                resp_valid,
    input  logic                probe_gt,
`ifdef SAR_EARLY_EXIT_EN
    input  logic                probe_eq,
`endif
    output logic signed [N-1:0] result
);

    localparam int unsigned    IdxW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [IdxW-1:0] IdxTop = IdxW'(N - 1);

    sar_state_e      state_q;
    logic [N-1:0]    acc_q;     // offset-binary bits decided so far
    logic [IdxW-1:0] idx_q;     // bit currently under trial
    logic [N-1:0]    trial;
    logic [N-1:0]    acc_next;

    // Trial value and the accumulator update implied by the comparator bit.
    always_comb begin
        trial    = acc_q | (N'(1) << idx_q);
        acc_next = probe_gt ? acc_q : trial;
    end

    // Probe is the trial mapped back to two's complement; quiet outside PROBE.
    always_comb begin
        probe = '0;
        if (state_q == S_PROBE) begin
            probe = N'(from_offset(SarMaxW'(trial), N));
        end
    end

    // Control FSM with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            idx_q       <= IdxTop;
            busy        <= 1'b0;
            done        <= 1'b0;
            probe_valid <= 1'b0;
            result      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_PROBE;
                        acc_q       <= '0;
                        idx_q       <= IdxTop;
                        busy        <= 1'b1;
                        probe_valid <= 1'b1;
                    end
                end
                S_PROBE: begin
                    if (resp_valid) begin
`ifdef SAR_EARLY_EXIT_EN
                        // Exact match wins over the ordering bit.
                        if (probe_eq) begin
                            acc_q       <= trial;
                            result      <= probe;
                            state_q     <= S_DONE;
                            done        <= 1'b1;
                            probe_valid <= 1'b0;
                        end else
`endif
                        begin
                            acc_q <= acc_next;
                            if (idx_q == '0) begin
                                result      <= N'(from_offset(SarMaxW'(acc_next), N));
                                state_q     <= S_DONE;
                                done        <= 1'b1;
                                probe_valid <= 1'b0;
                            end else begin
                                idx_q <= idx_q - IdxW'(1);
                            end
                        end
                    end
                end
                S_DONE: begin
                    // start is deliberately not sampled here.
                    state_q <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    probe_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search (N=8) against an interval-halving reference model.
module tb_sar_search;

    localparam int N = 8;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic                busy;
    logic                done;
    logic signed [N-1:0] probe;
    logic                probe_valid;
    logic                resp_valid;
    logic                probe_gt;
`ifdef SAR_EARLY_EXIT_EN
    logic                probe_eq;
`endif
    logic signed [N-1:0] result;

    int n_vec  = 0;
    int n_bad  = 0;
    int cyc    = 0;
    int done_cnt = 0;

    sar_search #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .probe       (probe),
        .probe_valid (probe_valid),
        .resp_valid  (resp_valid),
        .probe_gt    (probe_gt),
`ifdef SAR_EARLY_EXIT_EN
        .probe_eq    (probe_eq),
`endif
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter and done-pulse counter.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reset asserted mid-search: everything clears asynchronously, no done afterwards.
    task automatic do_abort(input int base_done);
        #3 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_pvalid", probe_valid, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_probe", probe, 0);
        resp_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - base_done, 0);
    endtask

    // One search. Model: the target lies in [lo, lo+2s); each probe is lo+s and a
    // "not greater" answer moves lo up. Responder answers after 'stall' waiting cycles.
    task automatic run_search(input int target, input int stall, input bit poke_start,
                              input int abort_at, output int lat, output int nresp);
        int lo, s, waited, pnum, c0, base_done, exp_probe;
        bit new_probe;
        logic signed [N-1:0] held;
        lo = -(1 << (N - 1));
        s = 1 << (N - 1);
        waited = 0;
        pnum = 0;
        nresp = 0;
        lat = -1;
        new_probe = 1'b1;
        held = '0;
        base_done = done_cnt;
        @(posedge clk);
        #1;
        start = 1'b1;
        c0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (done) begin
                lat = cyc - c0;
                check("result", result, target);
                check("busy_in_done", busy, 1);
                check("pvalid_in_done", probe_valid, 0);
                resp_valid = 1'b1;
                start = poke_start;
                @(posedge clk);
                #1;
                start = 1'b0;
                resp_valid = 1'b0;
                check("done_one_cycle", done, 0);
                check("idle_after_done", busy, 0);
                check("result_hold", result, target);
                check("one_done", done_cnt - base_done, 1);
                return;
            end
            if (probe_valid) begin
                exp_probe = lo + s;
                if (new_probe) begin
                    pnum++;
                    check("probe", probe, exp_probe);
                    held = probe;
                    new_probe = 1'b0;
                    waited = 0;
                    if (pnum == abort_at) begin
                        do_abort(base_done);
                        return;
                    end
                end else begin
                    check("probe_stable", probe, held);
                end
                if (poke_start) start = 1'($urandom_range(0, 1));
                if (waited == stall) begin
                    resp_valid = 1'b1;
                    probe_gt = exp_probe > target;
`ifdef SAR_EARLY_EXIT_EN
                    probe_eq = exp_probe == target;
`endif
                    if (exp_probe <= target) lo = exp_probe;
                    s = s / 2;
                    new_probe = 1'b1;
                    nresp++;
                end else begin
                    resp_valid = 1'b0;
                    probe_gt = 1'($urandom_range(0, 1));
`ifdef SAR_EARLY_EXIT_EN
                    probe_eq = 1'($urandom_range(0, 1));
`endif
                    waited++;
                end
            end else begin
                check("pvalid_while_busy", busy, 0);
            end
            @(posedge clk);
            #1;
        end
        check("timeout", 0, 1);
    endtask

    initial begin
        int lat, nr, t;
        rst_n = 1'b1;
        start = 1'b0;
        resp_valid = 1'b0;
        probe_gt = 1'b0;
`ifdef SAR_EARLY_EXIT_EN
        probe_eq = 1'b0;
`endif
        #3 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pvalid", probe_valid, 0);
        check("rst_probe", probe, 0);
        check("rst_result", result, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_search(37, 0, 1'b0, 0, lat, nr);
        check("lat_37", lat, 9);
        check("nresp_37", nr, 8);
        run_search(-128, 0, 1'b0, 0, lat, nr);
        check("lat_m128", lat, 9);
        run_search(127, 0, 1'b0, 0, lat, nr);
        check("lat_127", lat, 9);
        run_search(-1, 3, 1'b0, 0, lat, nr);
        check("lat_stall", lat, 33);

        // start pokes during PROBE and in the DONE cycle must be ignored.
        run_search(55, 1, 1'b1, 0, lat, nr);
        run_search(-90, 0, 1'b0, 0, lat, nr);
        check("lat_after_poke", lat, 9);

        // Reset at the 4th probe, then a fresh search.
        run_search(37, 0, 1'b0, 4, lat, nr);
        run_search(-5, 0, 1'b0, 0, lat, nr);
        check("lat_m5", lat, 9);

        run_search(0, 0, 1'b0, 0, lat, nr);
`ifdef SAR_EARLY_EXIT_EN
        check("lat_zero_eq", lat, 2);
        check("nresp_zero_eq", nr, 1);
`else
        check("lat_zero", lat, 9);
        check("nresp_zero", nr, 8);
`endif

        for (int i = 0; i < 25; i++) begin
            t = int'($urandom_range(0, 255)) - 128;
            run_search(t, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 0, lat, nr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sar_search.md
Name: sar_search

Overview:
- Successive-approximation controller: the requesting end of a signed compare interface.
- Recovers an unknown signed N-bit target by issuing trial probes to an external responder and consuming one "probe > target" bit per probe.
- The responder is normally comparator_lt with operands (target, probe), optionally registered or multi-cycle.
- Used to digitise values that are only observable through a comparator.

Parameters:
- N, 32, width of probe/result; signed two's complement.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a search; sampled only in IDLE.
- busy  output  1  high in PROBE and DONE.
- done  output  1  one-cycle pulse; result valid from this cycle.
- probe  output  N  signed trial value.
- probe_valid  output  1  probe is stable and a response is requested.
- resp_valid  input  1  responder returns a result for the current probe; ignored unless probe_valid.
- probe_gt  input  1  probe > target; qualified by resp_valid.
- result  output  N  recovered target; holds until the next done.

Behaviour:
- Reset (async assert, sync release): state IDLE; acc=0; idx=N-1; busy=0; done=0; probe_valid=0; result=0.
- Internal representation is offset-binary.
  - trial = acc | (1<<idx).
  - probe = trial ^ (1<<(N-1)), combinational from registers.
  - When not in PROBE, probe is driven as 0.
- IDLE: start=1 at an edge -> PROBE; acc=0; idx=N-1.
- PROBE: probe_valid=1.
  - probe holds stable until a cycle with resp_valid=1.
  - On that edge: if probe_gt=0, acc <= trial; else acc is unchanged.
  - If idx==0 -> DONE, result <= final acc ^ (1<<(N-1)); else idx <= idx-1.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE; probe_valid=0.
- Latency: with resp_valid tied to probe_valid, done is asserted N+1 cycles after the start edge. Each responder stall cycle adds 1.
- start while busy is ignored and does not queue.
- start in the DONE cycle is ignored.
- resp_valid while probe_valid=0 is ignored.
- Target range is the full signed range -2^(N-1)..2^(N-1)-1. The recovered value is always exact, with no overflow special case, because only compare bits are used.
- rst_n low mid-search aborts immediately to reset values. No done pulse; result is cleared to 0.

Optional Feature:
- Macro: SAR_EARLY_EXIT_EN.
- With macro: extra input probe_eq (1 bit, probe == target, qualified by resp_valid).
  - When resp_valid & probe_eq in PROBE: result <= probe; go to DONE regardless of idx.
  - probe_eq has priority over probe_gt.
- Without macro: no probe_eq port; every search takes exactly N responses.

Decomposition:
- Shared package sar_pkg:
  - state enum {S_IDLE, S_PROBE, S_DONE} (2-bit).
  - function to_offset/from_offset (MSB flip).
- No sub-module inside the block.
- Bench responder is a separate model, comparator_lt(a=target, b=probe) with optional delay.

Test Plan:
- N=8, target 37, zero-wait responder -> probes 0,64,32,48,40,36,38,37; result 37; done N+1=9 cycles after start.
- N=8, target -128 -> every probe_gt=1; result 0x80; target 127 -> every probe_gt=0; result 0x7F.
- N=8, target -1, responder stalls 3 cycles per probe:
  - probe/probe_valid stable during each stall.
  - result 0xFF; done 33 cycles after start.
- start pulsed during PROBE and in the DONE cycle -> ignored; exactly one done; following IDLE start runs normally.
- rst_n low at the 4th probe of a search for 37:
  - Outputs go to reset values asynchronously; no done.
  - A new search for -5 then returns 0xFB.
- With SAR_EARLY_EXIT_EN, target 0 -> first probe 0 with probe_eq=1; done 2 cycles after start; result 0. Without the macro, same target takes 8 responses.
